// File: rtl/reram_wb_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// reram_wb_cmd_sequencer_if
// Bundles the host command channel, the response channel and the Wishbone
// master bus of reram_wb_cmd_sequencer.
//   cmd_*  : host -> sequencer command push (valid/ready)
//   rsp_*  : sequencer -> host completion pop (valid/ready)
//   wbm_*  : Wishbone classic master towards the ReRAM slave wrapper
// modport master : the sequencer side
// modport slave  : the environment side (host logic + downstream slave)
// ---------------------------------------------------------------------------
interface reram_wb_cmd_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rd;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_rd;
    logic [31:0] rsp_dat;
    logic        rsp_err;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        input  cmd_valid, cmd_rd, cmd_adr, cmd_dat, cmd_sel,
        output cmd_ready,
        output rsp_valid, rsp_rd, rsp_dat, rsp_err,
        input  rsp_ready,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        output cmd_valid, cmd_rd, cmd_adr, cmd_dat, cmd_sel,
        input  cmd_ready,
        input  rsp_valid, rsp_rd, rsp_dat, rsp_err,
        output rsp_ready,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i
    );
endinterface

// File: rtl/reram_wb_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// reram_wb_cmd_sequencer
// Wishbone master in front of the ReRAM slave wrapper. Commands queue in a
// command FIFO, are issued one at a time as single classic cycles with an
// ack timeout, and every completion returns in order through a response FIFO.
// Ports:
//   wb_clk_i   : clock
//   wb_rst_i   : synchronous active-high reset
//   bus        : command, response and Wishbone master signals (master modport)
//   busy       : FSM not idle or commands still queued
//   err_count  : saturating count of timed-out transactions
// ---------------------------------------------------------------------------
module reram_wb_cmd_sequencer #(
    parameter int CMD_DEPTH      = 4,
    parameter int RSP_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_i,
    reram_wb_cmd_sequencer_if.master        bus,
    output logic                            busy,
    output logic [15:0]                     err_count
);
    // state  | meaning
    // S_IDLE | waiting for a queued command and a free response slot
    // S_BUS  | cyc/stb asserted, waiting for ack or timeout
    // S_DONE | one cycle with stb low before the next command
    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RSP_DEPTH);
    localparam int TW  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CAW:0]  CMD_FULL = (CAW+1)'(CMD_DEPTH);
    localparam logic [RAW:0]  RSP_FULL = (RAW+1)'(RSP_DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t          r_state;
    logic [TW-1:0]   r_tmo;

    // command entry: {rd, adr, dat, sel}
    logic [68:0]     r_cmd_mem [CMD_DEPTH];
    logic [CAW-1:0]  r_cmd_wp;
    logic [CAW-1:0]  r_cmd_rp;
    logic [CAW:0]    r_cmd_cnt;

    // response entry: {rd, dat, err}
    logic [33:0]     r_rsp_mem [RSP_DEPTH];
    logic [RAW-1:0]  r_rsp_wp;
    logic [RAW-1:0]  r_rsp_rp;
    logic [RAW:0]    r_rsp_cnt;

    logic            w_cmd_push;
    logic            w_cmd_pop;
    logic            w_rsp_push;
    logic            w_rsp_pop;
    logic            w_rsp_valid;
    logic            w_rsp_free;
    logic            w_ack_hit;
    logic            w_tmo_hit;
    logic [68:0]     w_cmd_head;
    logic [33:0]     w_rsp_head;
    logic [33:0]     w_rsp_in;

    assign w_cmd_head  = r_cmd_mem[r_cmd_rp];
    assign w_rsp_head  = r_rsp_mem[r_rsp_rp];
    assign w_rsp_valid = (r_rsp_cnt != '0);
    assign w_rsp_pop   = w_rsp_valid && bus.rsp_ready;
    // a slot being popped this cycle counts as free
    assign w_rsp_free  = (r_rsp_cnt != RSP_FULL) || w_rsp_pop;

    assign bus.cmd_ready = !wb_rst_i && (r_cmd_cnt != CMD_FULL);
    assign w_cmd_push    = bus.cmd_valid && bus.cmd_ready;
    assign w_cmd_pop     = (r_state == S_IDLE) && (r_cmd_cnt != '0) && w_rsp_free;

    // ack takes priority over a timeout landing on the same cycle
    assign w_ack_hit  = (r_state == S_BUS) && bus.wbm_ack_i;
    assign w_tmo_hit  = (r_state == S_BUS) && !bus.wbm_ack_i && (r_tmo == TMO_LAST);
    assign w_rsp_push = w_ack_hit || w_tmo_hit;
    assign w_rsp_in   = {bus.wbm_we_o,
                         (w_ack_hit && bus.wbm_we_o) ? bus.wbm_dat_i : 32'h0,
                         w_tmo_hit};

    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_rd    = w_rsp_valid && w_rsp_head[33];
    assign bus.rsp_dat   = w_rsp_valid ? w_rsp_head[32:1] : 32'h0;
    assign bus.rsp_err   = w_rsp_valid && w_rsp_head[0];

    assign busy = (r_state != S_IDLE) || (r_cmd_cnt != '0);

    always_ff @(posedge wb_clk_i) begin
        if (w_cmd_push)
            r_cmd_mem[r_cmd_wp] <= {bus.cmd_rd, bus.cmd_adr, bus.cmd_dat, bus.cmd_sel};
        if (w_rsp_push)
            r_rsp_mem[r_rsp_wp] <= w_rsp_in;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cmd_wp  <= '0;
            r_cmd_rp  <= '0;
            r_cmd_cnt <= '0;
            r_rsp_wp  <= '0;
            r_rsp_rp  <= '0;
            r_rsp_cnt <= '0;
        end else begin
            if (w_cmd_push) r_cmd_wp <= r_cmd_wp + 1'b1;
            if (w_cmd_pop)  r_cmd_rp <= r_cmd_rp + 1'b1;
            case ({w_cmd_push, w_cmd_pop})
                2'b10:   r_cmd_cnt <= r_cmd_cnt + 1'b1;
                2'b01:   r_cmd_cnt <= r_cmd_cnt - 1'b1;
                default: r_cmd_cnt <= r_cmd_cnt;
            endcase
            if (w_rsp_push) r_rsp_wp <= r_rsp_wp + 1'b1;
            if (w_rsp_pop)  r_rsp_rp <= r_rsp_rp + 1'b1;
            case ({w_rsp_push, w_rsp_pop})
                2'b10:   r_rsp_cnt <= r_rsp_cnt + 1'b1;
                2'b01:   r_rsp_cnt <= r_rsp_cnt - 1'b1;
                default: r_rsp_cnt <= r_rsp_cnt;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state       <= S_IDLE;
            r_tmo         <= '0;
            bus.wbm_cyc_o <= 1'b0;
            bus.wbm_stb_o <= 1'b0;
            bus.wbm_we_o  <= 1'b0;
            bus.wbm_sel_o <= 4'h0;
            bus.wbm_adr_o <= 32'h0;
            bus.wbm_dat_o <= 32'h0;
            err_count     <= 16'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_pop) begin
                        bus.wbm_cyc_o <= 1'b1;
                        bus.wbm_stb_o <= 1'b1;
                        // downstream we polarity: 1 = read
                        bus.wbm_we_o  <= w_cmd_head[68];
                        bus.wbm_adr_o <= w_cmd_head[67:36];
                        bus.wbm_dat_o <= w_cmd_head[68] ? 32'h0 : w_cmd_head[35:4];
                        bus.wbm_sel_o <= w_cmd_head[3:0];
                        r_tmo         <= '0;
                        r_state       <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (w_rsp_push) begin
                        bus.wbm_cyc_o <= 1'b0;
                        bus.wbm_stb_o <= 1'b0;
                        r_state       <= S_DONE;
                        if (w_tmo_hit && (err_count != 16'hFFFF))
                            err_count <= err_count + 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reram_wb_cmd_sequencer.sv
module tb_reram_wb_cmd_sequencer;
    localparam int CMD_DEPTH = 4;
    localparam int RSP_DEPTH = 4;
    localparam int TMO       = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [15:0] err_count;

    reram_wb_cmd_sequencer_if bus();

    reram_wb_cmd_sequencer #(
        .CMD_DEPTH(CMD_DEPTH),
        .RSP_DEPTH(RSP_DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus),
        .busy     (busy),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // environment controls: slv_mode 0 = never ack, 1 = ack after latency, 2 = ack every cycle
    int slv_mode = 1;
    int slv_lat  = 0;
    bit slv_rand = 1'b0;
    int rsp_mode = 1;      // 0 = ready low, 1 = ready high, 2 = random
    int n_acks   = 0;
    int n_rsp    = 0;
    int stb_cnt  = 0;
    int cur_lat  = 0;

    bit [31:0]   smem [bit [31:0]];   // downstream slave memory
    bit [31:0]   rmem [bit [31:0]];   // reference memory, updated in command order
    logic [33:0] exp_q [$];           // expected {rd, dat, err} in command order

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = sel[b] ? nw[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

    // reference: a command's completion follows from the commands before it
    task automatic model_push(input logic rd, input logic [31:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel, input logic err);
        logic [31:0] old;
        logic [31:0] d;
        old = rmem.exists(adr) ? rmem[adr] : 32'h0;
        d   = 32'h0;
        if (!err) begin
            if (rd) d = old;
            else    rmem[adr] = merge(old, dat, sel);
        end
        exp_q.push_back({rd, d, err});
    endtask

    task automatic send(input logic rd, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic err);
        int w;
        w = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_rd    = rd;
        bus.cmd_adr   = adr;
        bus.cmd_dat   = dat;
        bus.cmd_sel   = sel;
        while (!bus.cmd_ready && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk("cmd_accept", bus.cmd_ready, 1);
        if (bus.cmd_ready) model_push(rd, adr, dat, sel, err);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_stb(input string tag);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus.wbm_stb_o && w < 3000);
        chk(tag, bus.wbm_stb_o, 1);
    endtask

    task automatic count_stb(output int n);
        n = 0;
        while (bus.wbm_stb_o && n < 3000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string tag);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(exp_q.size() == 0 && !busy && !bus.rsp_valid && !bus.wbm_stb_o) && w < 5000);
        chk(tag, (w < 5000), 1);
    endtask

    // downstream slave
    initial begin : slave
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            bus.wbm_dat_i = $urandom;
            bus.wbm_ack_i = 1'b0;
            if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
                if (stb_cnt == 0) cur_lat = slv_rand ? int'($urandom_range(0, 4)) : slv_lat;
                if (slv_mode == 1 && stb_cnt == cur_lat) begin
                    bus.wbm_ack_i = 1'b1;
                    n_acks++;
                    if (bus.wbm_we_o)
                        bus.wbm_dat_i = smem.exists(bus.wbm_adr_o) ? smem[bus.wbm_adr_o] : 32'h0;
                    else
                        smem[bus.wbm_adr_o] = merge(smem.exists(bus.wbm_adr_o) ?
                                                    smem[bus.wbm_adr_o] : 32'h0,
                                                    bus.wbm_dat_o, bus.wbm_sel_o);
                end
                stb_cnt++;
            end else begin
                stb_cnt = 0;
            end
            if (slv_mode == 2) bus.wbm_ack_i = 1'b1;
        end
    end

    // response consumer
    initial begin : consumer
        logic [33:0] e;
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rsp_mode)
                0:       bus.rsp_ready = 1'b0;
                1:       bus.rsp_ready = 1'b1;
                default: bus.rsp_ready = 1'($urandom_range(0, 1));
            endcase
            if (!rst && bus.rsp_valid && bus.rsp_ready) begin
                chk("rsp_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rsp_word", {bus.rsp_rd, bus.rsp_dat, bus.rsp_err}, e);
                end
                n_rsp++;
            end
        end
    end

    initial begin : main
        int n;
        int a0;
        int r0;
        logic [31:0] xa;
        bus.cmd_valid = 1'b0;
        bus.cmd_rd    = 1'b0;
        bus.cmd_adr   = 32'h0;
        bus.cmd_dat   = 32'h0;
        bus.cmd_sel   = 4'h0;

        // reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready_low", bus.cmd_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_cmd_ready", bus.cmd_ready, 1);
        chk("rel_wbm_ctl", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o}, 0);
        chk("rel_wbm_adr", bus.wbm_adr_o, 0);
        chk("rel_wbm_dat", bus.wbm_dat_o, 0);
        chk("rel_rsp", {bus.rsp_valid, bus.rsp_rd, bus.rsp_dat, bus.rsp_err}, 0);
        chk("rel_busy_errcnt", {busy, err_count}, 0);

        // write with latency check
        slv_lat = 2;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_rd    = 1'b0;
        bus.cmd_adr   = 32'h3000_0004;
        bus.cmd_dat   = 32'hA5A5_0001;
        bus.cmd_sel   = 4'hF;
        chk("t1_ready", bus.cmd_ready, 1);
        model_push(1'b0, 32'h3000_0004, 32'hA5A5_0001, 4'hF, 1'b0);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        chk("t1_stb_early", bus.wbm_stb_o, 0);
        @(posedge clk);
        #1;
        chk("t1_cyc_stb", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o}, 3'b110);
        chk("t1_adr", bus.wbm_adr_o, 32'h3000_0004);
        chk("t1_dat_sel", {bus.wbm_dat_o, bus.wbm_sel_o}, {32'hA5A5_0001, 4'hF});
        wait_idle("t1_idle");

        // read back
        slv_lat = 1;
        send(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1'b0);
        wait_stb("t2_stb");
        chk("t2_we_adr", {bus.wbm_we_o, bus.wbm_adr_o}, {1'b1, 32'h3000_0004});
        chk("t2_dat_o_zero", bus.wbm_dat_o, 0);
        wait_idle("t2_idle");

        // response backpressure fills both FIFOs
        slv_rand = 1'b1;
        rsp_mode = 0;
        a0 = n_acks;
        r0 = n_rsp;
        for (int i = 0; i < 8; i++)
            send(1'($urandom_range(0, 1)), 32'h3000_0000 + 32'($urandom_range(0, 7)) * 4,
                 $urandom, 4'($urandom_range(0, 15)), 1'b0);
        repeat (30) @(negedge clk);
        chk("t3_acks_at_full", n_acks - a0, 4);
        chk("t3_cmd_ready_full", bus.cmd_ready, 0);
        chk("t3_rsp_valid", bus.rsp_valid, 1);
        repeat (20) @(negedge clk);
        chk("t3_stb_held_low", bus.wbm_stb_o, 0);
        chk("t3_no_more_acks", n_acks - a0, 4);
        rsp_mode = 1;
        wait_idle("t3_idle");
        chk("t3_rsp_count", n_rsp - r0, 8);
        slv_rand = 1'b0;

        // timeout, then next queued command completes normally
        slv_mode = 0;
        slv_lat  = 0;
        send(1'b1, 32'h3000_0010, 32'h0, 4'hF, 1'b1);
        send(1'b0, 32'h3000_0014, 32'h1234_5678, 4'h3, 1'b0);
        wait_stb("t4_stb");
        count_stb(n);
        slv_mode = 1;
        chk("t4_stb_cycles", n, TMO);
        wait_idle("t4_idle");
        chk("t4_err_count", err_count, 1);

        // reset during a bus cycle
        slv_mode = 0;
        send(1'b1, 32'h3000_0018, 32'h0, 4'hF, 1'b0);
        wait_stb("t5_stb");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("t5_cyc_stb", {bus.wbm_cyc_o, bus.wbm_stb_o}, 0);
        chk("t5_rsp_valid", bus.rsp_valid, 0);
        chk("t5_err_count", err_count, 0);
        chk("t5_busy", busy, 0);
        chk("t5_cmd_ready_rst", bus.cmd_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_cmd_ready_rel", bus.cmd_ready, 1);
        slv_mode = 2;
        repeat (6) @(negedge clk);
        chk("t5_late_ack_ignored", {bus.rsp_valid, busy, bus.wbm_stb_o, err_count}, 0);
        slv_mode = 1;
        repeat (2) @(negedge clk);

        // ack exactly on the last timeout cycle, then one cycle too late
        xa = 32'h3000_001C;
        slv_lat = 0;
        send(1'b0, xa, 32'h5A5A_C3C3, 4'hF, 1'b0);
        wait_idle("t6_wr_idle");
        slv_lat = TMO - 1;
        send(1'b1, xa, 32'h0, 4'hF, 1'b0);
        wait_stb("t6_stb");
        count_stb(n);
        chk("t6_stb_cycles", n, TMO);
        wait_idle("t6_idle");
        chk("t6_err_count", err_count, 0);
        slv_lat = TMO;
        send(1'b1, xa, 32'h0, 4'hF, 1'b1);
        wait_idle("t6b_idle");
        chk("t6b_err_count", err_count, 1);

        // randomized traffic with random backpressure
        slv_rand = 1'b1;
        rsp_mode = 2;
        r0 = n_rsp;
        for (int i = 0; i < 40; i++) begin
            send(1'($urandom_range(0, 1)), 32'h3000_0000 + 32'($urandom_range(0, 7)) * 4,
                 $urandom, 4'($urandom_range(0, 15)), 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rsp_mode = 1;
        wait_idle("rand_idle");
        chk("rand_rsp_count", n_rsp - r0, 40);
        chk("rand_err_count", err_count, 1);
        chk("rand_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
